// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and core-wide constants.
// Holds the default data/PC width, imem word-address width, reset PC and
// instruction size, plus the per-cycle action decode used by fetch_unit.
package fetch_unit_pkg;

    localparam int          DATA_WIDTH      = 32;
    localparam int          IMEM_ADDR_WIDTH = 10;
    localparam logic [31:0] RESET_PC        = 32'h0000_0000;
    localparam int          INSTR_BYTES     = 4;

    // What the fetch stage does this cycle, in priority order.
    typedef enum logic [2:0] {
        ACT_REDIRECT     = 3'd0,  // aligned redirect: kill response, fetch target
        ACT_BAD_REDIRECT = 3'd1,  // misaligned redirect: raise fault, fetch nothing
        ACT_FAULTED      = 3'd2,  // sticky fault: no requests
        ACT_STALL        = 3'd3,  // pending response not consumed: re-read it
        ACT_FETCH        = 3'd4,  // issue next sequential request
        ACT_IDLE         = 3'd5   // fetch disabled: drop response slot
    } fetch_action_e;

    // A byte PC is fetchable only on an instruction boundary.
    function automatic logic is_misaligned(input logic [1:0] pc_low);
        return pc_low != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting directly in front of a 1-cycle-latency
// instruction memory. Owns the PC, drives the imem word address every cycle,
// pairs each returning word with its PC and offers {instr, inst_pc} to decode
// over a valid/ready handshake.
//
// The imem has no read enable, so a stall is implemented by re-issuing the
// address of the held response; the memory then returns the same word again
// and instr stays stable without a local instruction buffer.
//
// Optional feature, macro FETCH_MISALIGN_CHECK_EN:
//   defined   - a redirect to a PC with bits [1:0] != 0 raises a sticky
//               fetch_fault (cleared by an aligned redirect or rst) and
//               suppresses all fetching while set.
//   undefined - redirect targets are forced to a word boundary and
//               fetch_fault is constant 0.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                           DATA_WIDTH = fetch_unit_pkg::DATA_WIDTH,
    parameter int                           ADDR_WIDTH = fetch_unit_pkg::IMEM_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0]        RESET_PC   = DATA_WIDTH'(fetch_unit_pkg::RESET_PC)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [DATA_WIDTH-1:0]   redirect_pc,
    output logic [ADDR_WIDTH-1:0]   imem_address,
    input  logic [DATA_WIDTH-1:0]   imem_read_data,
    input  logic                    imem_read_valid,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [DATA_WIDTH-1:0]   instr,
    output logic [DATA_WIDTH-1:0]   inst_pc,
    output logic                    fetch_fault
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(INSTR_BYTES);

    // pc_reg: next PC to request; rsp_pc_reg/rsp_valid_reg: the request whose
    // data is on imem_read_data this cycle.
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [DATA_WIDTH-1:0] rsp_pc_reg;
    logic [DATA_WIDTH-1:0] rsp_pc_next;
    logic                  rsp_valid_reg;
    logic                  rsp_valid_next;
    logic                  fault_reg;

    logic [DATA_WIDTH-1:0] target_pc;
    logic                  target_misaligned;
    fetch_action_e         action;

`ifdef FETCH_MISALIGN_CHECK_EN
    // Keep the raw target so a trap handler can see the faulting PC.
    assign target_pc         = redirect_pc;
    assign target_misaligned = is_misaligned(redirect_pc[1:0]);
`else
    // Low PC bits are meaningless for a word-addressed imem; drop them.
    assign target_pc         = redirect_pc & ~(PC_STEP - 1'b1);
    assign target_misaligned = 1'b0;
`endif

    // Select this cycle's action; redirect beats fault beats stall beats fetch.
    // A response that imem has not yet marked valid is held exactly like an
    // unaccepted one, so the same address is re-read until it arrives.
    always_comb begin
        action = ACT_IDLE;
        if (redirect_valid) begin
            action = target_misaligned ? ACT_BAD_REDIRECT : ACT_REDIRECT;
        end else if (fault_reg) begin
            action = ACT_FAULTED;
        end else if (rsp_valid_reg && (!inst_ready || !imem_read_valid)) begin
            action = ACT_STALL;
        end else if (fetch_en) begin
            action = ACT_FETCH;
        end
    end

    // Word address to imem for the request being issued this cycle.
    always_comb begin
        imem_address = pc_reg[ADDR_WIDTH+1:2];
        case (action)
            ACT_REDIRECT,
            ACT_BAD_REDIRECT: imem_address = target_pc[ADDR_WIDTH+1:2];
            ACT_STALL:        imem_address = rsp_pc_reg[ADDR_WIDTH+1:2];
            default:          imem_address = pc_reg[ADDR_WIDTH+1:2];
        endcase
    end

    // Next-state for the PC and the response slot.
    always_comb begin
        pc_next        = pc_reg;
        rsp_pc_next    = rsp_pc_reg;
        rsp_valid_next = rsp_valid_reg;
        case (action)
            ACT_REDIRECT: begin
                rsp_pc_next    = target_pc;
                rsp_valid_next = 1'b1;
                pc_next        = target_pc + PC_STEP;
            end
            ACT_BAD_REDIRECT: begin
                rsp_pc_next    = target_pc;
                rsp_valid_next = 1'b0;
                pc_next        = target_pc + PC_STEP;
            end
            ACT_FAULTED: begin
                rsp_valid_next = 1'b0;
            end
            ACT_STALL: begin
                rsp_valid_next = rsp_valid_reg;
            end
            ACT_FETCH: begin
                rsp_pc_next    = pc_reg;
                rsp_valid_next = 1'b1;
                pc_next        = pc_reg + PC_STEP;
            end
            default: begin
                rsp_valid_next = 1'b0;
            end
        endcase
    end

    // PC and response-slot registers; reset discards any pending response.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg        <= RESET_PC;
            rsp_pc_reg    <= RESET_PC;
            rsp_valid_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            rsp_pc_reg    <= rsp_pc_next;
            rsp_valid_reg <= rsp_valid_next;
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_next;

    // Fault is set by a misaligned redirect and cleared only by an aligned one.
    always_comb begin
        fault_next = fault_reg;
        if (action == ACT_BAD_REDIRECT) begin
            fault_next = 1'b1;
        end else if (action == ACT_REDIRECT) begin
            fault_next = 1'b0;
        end
    end

    // Sticky misalignment fault register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_reg <= 1'b0;
        end else begin
            fault_reg <= fault_next;
        end
    end
`else
    assign fault_reg = 1'b0;
`endif

    // The response in flight is offered unless it is being killed by a
    // redirect, blocked by a fault, not yet returned, or reset is active.
    assign inst_valid  = rsp_valid_reg & imem_read_valid & ~redirect_valid
                       & ~fault_reg & ~rst;
    assign fetch_fault = fault_reg & ~rst;
    assign inst_pc     = rsp_pc_reg;
    assign instr       = imem_read_data;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit (ADDR_WIDTH=4 so imem wrap is exercised).
// A cycle-level reference model checks every cycle at the falling edge; a
// directed vector table carries hand-computed expectations for each cycle.
// Honours FETCH_MISALIGN_CHECK_EN for the misaligned-redirect rows.
module tb_fetch_unit;

    localparam int          AW    = 4;
    localparam int          WORDS = 16;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [AW-1:0] imem_address;
    logic [31:0] imem_read_data;
    logic        imem_read_valid;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instr;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;
    bit started = 0;

    fetch_unit #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .RESET_PC   (RPC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_address    (imem_address),
        .imem_read_data  (imem_read_data),
        .imem_read_valid (imem_read_valid),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .instr           (instr),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    // Distinct content per imem word.
    function automatic logic [31:0] mem_word(input int idx);
        return 32'hC0DE_0000 | (32'(idx) * 32'h0000_0111);
    endfunction

    // Word index a byte PC lands on in a 2^AW-word imem.
    function automatic int word_of(input logic [31:0] pc);
        return int'((pc / 4) % WORDS);
    endfunction

    // 1-cycle-latency instruction memory.
    always @(posedge clk) imem_read_data <= mem_word(int'(imem_address));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model, checked every cycle ----------------
    bit          m_have;   // an instruction is in flight toward decode
    bit          m_fault;
    logic [31:0] m_pc;     // PC of the in-flight instruction
    logic [31:0] m_next;   // next sequential PC to request

    always @(negedge clk) begin
        logic [31:0] eff;
        bit          mis;
        bit          exp_valid;
        bit          hold;
        int          exp_addr;
        if (started) begin
            eff = redirect_pc;
            mis = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            mis = (redirect_pc % 4) != 0;
`else
            eff = redirect_pc - (redirect_pc % 4);
`endif
            if (rst) begin
                check("model_rst_valid", 32'(inst_valid), 32'd0);
                check("model_rst_fault", 32'(fetch_fault), 32'd0);
                m_have  = 0;
                m_fault = 0;
                m_pc    = RPC;
                m_next  = RPC;
            end else begin
                exp_valid = m_have && imem_read_valid && !redirect_valid && !m_fault;
                hold      = m_have && (!inst_ready || !imem_read_valid);
                if (redirect_valid)  exp_addr = word_of(eff);
                else if (m_fault)    exp_addr = word_of(m_next);
                else if (hold)       exp_addr = word_of(m_pc);
                else                 exp_addr = word_of(m_next);
                check("model_valid", 32'(inst_valid), 32'(exp_valid));
                check("model_fault", 32'(fetch_fault), 32'(m_fault));
                check("model_addr", 32'(imem_address), 32'(exp_addr));
                if (exp_valid) begin
                    check("model_pc", inst_pc, m_pc);
                    check("model_instr", instr, mem_word(word_of(m_pc)));
                end
                if (redirect_valid) begin
                    m_fault = mis;
                    m_have  = !mis;
                    m_pc    = eff;
                    m_next  = eff + 32'd4;
                end else if (m_fault) begin
                    m_have = 0;
                end else if (hold) begin
                    m_have = 1;
                end else if (fetch_en) begin
                    m_have = 1;
                    m_pc   = m_next;
                    m_next = m_next + 32'd4;
                end else begin
                    m_have = 0;
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        bit          rst;
        bit          en;
        bit          rdy;
        bit          rv;
        logic [31:0] rpc;
        bit          iv;
        bit          v;      // expected inst_valid
        int          pc;     // expected inst_pc (only when v)
        int          addr;   // expected imem_address, -1 = don't care
        bit          f;      // expected fetch_fault
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t vec(bit r, bit en, bit rdy, bit rv, logic [31:0] rpc, bit iv,
                                 bit v, int pc, int addr, bit f);
        vec_t t;
        t.rst = r; t.en = en; t.rdy = rdy; t.rv = rv; t.rpc = rpc; t.iv = iv;
        t.v = v; t.pc = pc; t.addr = addr; t.f = f;
        return t;
    endfunction

    initial begin
        //                rst en rdy rv rpc     iv  v  pc    addr f
        tbl.push_back(vec(1, 0, 1, 0, 32'h0,  1, 0, 0,    -1,  0));
        tbl.push_back(vec(1, 0, 1, 0, 32'h0,  1, 0, 0,    -1,  0));
        // sequential fetch from reset
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 0, 0,     0,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h0,   1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h4,   2,  0));
        // decode stalls three cycles on pc 0x8
        tbl.push_back(vec(0, 1, 0, 0, 32'h0,  1, 1, 'h8,   2,  0));
        tbl.push_back(vec(0, 1, 0, 0, 32'h0,  1, 1, 'h8,   2,  0));
        tbl.push_back(vec(0, 1, 0, 0, 32'h0,  1, 1, 'h8,   2,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h8,   3,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'hC,   4,  0));
        // redirect to 0x40 kills pending 0x10
        tbl.push_back(vec(0, 1, 1, 1, 32'h40, 1, 0, 0,     0,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h40,  1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h44,  2,  0));
        // redirect during a stall drops the stalled 0x48
        tbl.push_back(vec(0, 1, 0, 0, 32'h0,  1, 1, 'h48,  2,  0));
        tbl.push_back(vec(0, 1, 0, 1, 32'h20, 1, 0, 0,     8,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h20,  9,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h24, 10,  0));
        // imem data not valid: hold and re-read 0x28
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  0, 0, 0,    10,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h28, 11,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h2C, 12,  0));
        // fetch disabled for two cycles
        tbl.push_back(vec(0, 0, 1, 0, 32'h0,  1, 1, 'h30, 13,  0));
        tbl.push_back(vec(0, 0, 1, 0, 32'h0,  1, 0, 0,    13,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 0, 0,    13,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h34, 14,  0));
        // wrap of the 16-word imem at 0x3C -> 0x40
        tbl.push_back(vec(0, 1, 1, 1, 32'h3C, 1, 0, 0,    15,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h3C,  0,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h40,  1,  0));
        // misaligned redirect to 0x42
        tbl.push_back(vec(0, 1, 1, 1, 32'h42, 1, 0, 0,     0,  0));
`ifdef FETCH_MISALIGN_CHECK_EN
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 0, 0,     1,  1));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 0, 0,     1,  1));
        tbl.push_back(vec(0, 1, 1, 1, 32'h80, 1, 0, 0,     0,  1));
`else
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h40,  1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h44,  2,  0));
        tbl.push_back(vec(0, 1, 1, 1, 32'h80, 1, 0, 0,     0,  0));
`endif
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h80,  1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h84,  2,  0));
        // reset in the middle of a stall
        tbl.push_back(vec(0, 1, 0, 0, 32'h0,  1, 1, 'h88,  2,  0));
        tbl.push_back(vec(1, 1, 0, 0, 32'h0,  1, 0, 0,    -1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 0, 0,     0,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h0,   1,  0));
        tbl.push_back(vec(0, 1, 1, 0, 32'h0,  1, 1, 'h4,   2,  0));

        foreach (tbl[i]) begin
            rst             = tbl[i].rst;
            fetch_en        = tbl[i].en;
            inst_ready      = tbl[i].rdy;
            redirect_valid  = tbl[i].rv;
            redirect_pc     = tbl[i].rpc;
            imem_read_valid = tbl[i].iv;
            started         = 1;
            #2;
            check($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(tbl[i].v));
            check($sformatf("vec%0d_fault", i), 32'(fetch_fault), 32'(tbl[i].f));
            if (tbl[i].addr >= 0)
                check($sformatf("vec%0d_addr", i), 32'(imem_address), 32'(tbl[i].addr));
            if (tbl[i].v) begin
                check($sformatf("vec%0d_pc", i), inst_pc, 32'(tbl[i].pc));
                check($sformatf("vec%0d_instr", i), instr, mem_word(word_of(32'(tbl[i].pc))));
            end
            $display("cyc %0d: rst=%0b en=%0b rdy=%0b rv=%0b rpc=%h -> valid=%0b pc=%h addr=%0d fault=%0b",
                     i, rst, fetch_en, inst_ready, redirect_valid, redirect_pc,
                     inst_valid, inst_pc, imem_address, fetch_fault);
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
